// File: rtl/overlay_videogen.sv
// overlay_videogen: flashing measurement fields plus bitmap text rows for the lag-tester HDMI path.
// Sits between the timing generator and the TMDS encoder.
//
// Ports:
//   clock, reset_n          pixel clock, asynchronous active-low reset
//   frame_tick              one-cycle pulse at the first active pixel of each frame
//   de, vis_x, vis_y        active-video qualifier and visible-area coordinates
//   mode, arm               run mode (00 periodic, 01 continuous, 10 off, 11 single-shot), arm
//   field_x0/x1, field_y    field horizontal extent and per-field {start,end} vertical bands
//   text_x, text_y          text origin (text_x in scaled units)
//   h_shift, v_shift        text scaling
//   row_len, bitmap         per-row widths in bits and the packed MSB-first text bitmap
//   fg_rgb/bg_rgb/field_rgb colours
//   starttrigger, lit       trigger pulse and field-lit status
//   data, data_valid        pixel RGB and de, three cycles after the coordinates
module overlay_videogen #(
  parameter int unsigned TEXT_ROWS    = 4,
  parameter int unsigned LINE_BITS    = 512,
  parameter int unsigned NUM_FIELDS   = 3,
  parameter int unsigned FRAME_PERIOD = 32,
  parameter int unsigned ON_FRAMES    = 2,
  parameter int unsigned DITHER       = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    frame_tick,
  input  logic                    de,
  input  logic [11:0]             vis_x,
  input  logic [11:0]             vis_y,
  input  logic [1:0]              mode,
  input  logic                    arm,
  input  logic [11:0]             field_x0,
  input  logic [11:0]             field_x1,
  input  logic [NUM_FIELDS*24-1:0] field_y,
  input  logic [11:0]             text_x,
  input  logic [11:0]             text_y,
  input  logic [1:0]              h_shift,
  input  logic [1:0]              v_shift,
  input  logic [TEXT_ROWS*12-1:0] row_len,
  input  logic [LINE_BITS-1:0]    bitmap,
  input  logic [23:0]             fg_rgb,
  input  logic [23:0]             bg_rgb,
  input  logic [23:0]             field_rgb,
  output logic                    starttrigger,
  output logic                    lit,
  output logic [23:0]             data,
  output logic                    data_valid
);

  localparam logic [1:0] ModePeriodic = 2'b00;
  localparam logic [1:0] ModeCont     = 2'b01;
  localparam logic [1:0] ModeOff      = 2'b10;
  localparam logic [1:0] ModeSingle   = 2'b11;

  typedef enum logic [1:0] {StWait, StOn, StDone} ss_state_e;

  // ---------------------------------------------------------------------------
  // Frame sequencer
  // ---------------------------------------------------------------------------
  ss_state_e   state_q, state_d;
  logic [5:0]  fc_q, fc_d, fc_cur;
  logic [2:0]  dith_q, dith_d;
  logic [5:0]  burst_q, burst_d;
  logic [1:0]  mode_q, mode_d;
  logic        arm_q, arm_d;
  logic        lit_q, lit_d;
  logic        trig_q, trig_d;
  logic        mode_change;
  logic [6:0]  period;

  assign mode_change = (mode != mode_q);
  // dith advances once per completed period, so successive periods grow by one frame.
  assign period = 7'(FRAME_PERIOD) + ((DITHER != 0) ? {4'b0, dith_q} : 7'd0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWait;
      fc_q    <= '0;
      dith_q  <= '0;
      burst_q <= '0;
      mode_q  <= ModePeriodic;
      arm_q   <= 1'b0;
      lit_q   <= 1'b0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      fc_q    <= fc_d;
      dith_q  <= dith_d;
      burst_q <= burst_d;
      mode_q  <= mode_d;
      arm_q   <= arm_d;
      lit_q   <= lit_d;
      trig_q  <= trig_d;
    end
  end

  // Single-shot next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:  if (frame_tick && (mode == ModeSingle) && !mode_change && arm_q) state_d = StOn;
      StOn:    if (frame_tick && (mode == ModeSingle) && (burst_q == '0)) state_d = StDone;
      StDone:  state_d = StWait;
      default: state_d = StWait;
    endcase
    // Leaving single-shot, or entering it, always restarts from WAIT.
    if (frame_tick && ((mode != ModeSingle) || mode_change)) state_d = StWait;
  end

  // Sequencer outputs and counters.
  always_comb begin
    fc_d    = fc_q;
    fc_cur  = fc_q;
    dith_d  = dith_q;
    burst_d = burst_q;
    mode_d  = mode_q;
    arm_d   = arm_q;
    lit_d   = lit_q;
    trig_d  = 1'b0;
    if (arm && (state_q != StOn)) arm_d = 1'b1;
    if (frame_tick) begin
      mode_d = mode;
      unique case (mode)
        ModePeriodic: begin
          fc_cur = mode_change ? 6'd0 : fc_q;
          if (fc_cur == 6'd0) begin
            trig_d = 1'b1;
            lit_d  = 1'b1;
          end else if (fc_cur >= 6'(ON_FRAMES)) begin
            lit_d = 1'b0;
          end
          if ({1'b0, fc_cur} == period - 7'd1) begin
            fc_d   = '0;
            dith_d = dith_q + 3'd1;
          end else begin
            fc_d = fc_cur + 6'd1;
          end
        end
        ModeCont: begin
          fc_d   = '0;
          lit_d  = 1'b1;
          trig_d = 1'b1;
        end
        ModeOff: begin
          fc_d  = '0;
          lit_d = 1'b0;
        end
        ModeSingle: begin
          fc_d = '0;
          if (mode_change) begin
            lit_d = 1'b0;
            arm_d = 1'b0;
          end else begin
            unique case (state_q)
              StWait: begin
                if (arm_q) begin
                  trig_d  = 1'b1;
                  lit_d   = 1'b1;
                  burst_d = 6'(ON_FRAMES - 1);
                  arm_d   = 1'b0;
                end
              end
              StOn: begin
                if (burst_q == '0) lit_d = 1'b0;
                else               burst_d = burst_q - 6'd1;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign starttrigger = trig_q;
  assign lit          = lit_q;

  // ---------------------------------------------------------------------------
  // Pixel pipeline
  // ---------------------------------------------------------------------------
  logic [11:0] x1_q, y1_q;
  logic        de1_q;
  logic        field2_q, bit2_q, de2_q;
  logic [23:0] data_q;
  logic        dv_q;

  logic [12:0] sx, row_h, row_top, row_bot, x13, y13, tx13;
  logic [11:0] len;
  logic [15:0] base, off_sel;
  logic        band_hit, field_hit, row_found, text_bit;
  logic [LINE_BITS-1:0] shifted;

  always_comb begin
    x13      = {1'b0, x1_q};
    y13      = {1'b0, y1_q};
    tx13     = {1'b0, text_x};
    sx       = x13 >> h_shift;
    row_h    = 13'd16 << v_shift;
    band_hit = 1'b0;
    for (int i = 0; i < int'(NUM_FIELDS); i++) begin
      if ((y1_q >= field_y[i*24+12 +: 12]) && (y1_q < field_y[i*24 +: 12])) band_hit = 1'b1;
    end
    field_hit = lit_q && (x1_q >= field_x0) && (x1_q < field_x1) && band_hit;

    // Rows are scanned in index order; the first hit claims the pixel.
    base      = '0;
    off_sel   = '0;
    row_found = 1'b0;
    row_top   = '0;
    row_bot   = '0;
    len       = '0;
    for (int r = 0; r < int'(TEXT_ROWS); r++) begin
      len     = row_len[r*12 +: 12];
      row_top = {1'b0, text_y} + 13'(r) * row_h;
      row_bot = row_top + row_h;
      if (!row_found && (y13 >= row_top) && (y13 < row_bot) &&
          (sx >= tx13) && (sx < tx13 + {1'b0, len})) begin
        row_found = 1'b1;
        off_sel   = base + {3'b0, sx - tx13};
      end
      base = base + {4'b0, len};
    end
    // A shift of LINE_BITS or more empties the vector, so out-of-range offsets read 0.
    shifted  = bitmap << off_sel;
    text_bit = row_found && shifted[LINE_BITS-1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x1_q     <= '0;
      y1_q     <= '0;
      de1_q    <= 1'b0;
      field2_q <= 1'b0;
      bit2_q   <= 1'b0;
      de2_q    <= 1'b0;
      data_q   <= '0;
      dv_q     <= 1'b0;
    end else begin
      x1_q     <= vis_x;
      y1_q     <= vis_y;
      de1_q    <= de;
      field2_q <= field_hit;
      bit2_q   <= text_bit;
      de2_q    <= de1_q;
      dv_q     <= de2_q;
      if (!de2_q)        data_q <= '0;
      else if (field2_q) data_q <= field_rgb;
      else if (bit2_q)   data_q <= fg_rgb;
      else               data_q <= bg_rgb;
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;

endmodule

// File: tb/tb_overlay_videogen.sv
// Self-checking bench for overlay_videogen: a scoreboard queue holds expected values with the
// cycle they are due; a monitor pops and compares them just after each rising edge.
module tb_overlay_videogen;

  localparam int unsigned LB = 512;
  localparam int unsigned TR = 4;
  localparam int unsigned NF = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              frame_tick, de, arm;
  logic [11:0]       vis_x, vis_y, field_x0, field_x1, text_x, text_y;
  logic [1:0]        mode, h_shift, v_shift;
  logic [NF*24-1:0]  field_y;
  logic [TR*12-1:0]  row_len;
  logic [LB-1:0]     bitmap;
  logic [23:0]       fg_rgb, bg_rgb, field_rgb;
  logic              trig0, lit0, dv0, trig1, lit1, dv1;
  logic [23:0]       data0, data1;

  always #5 clock = ~clock;

  overlay_videogen #(
    .TEXT_ROWS(TR), .LINE_BITS(LB), .NUM_FIELDS(NF),
    .FRAME_PERIOD(4), .ON_FRAMES(2), .DITHER(0)
  ) u_dut0 (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .de(de),
    .vis_x(vis_x), .vis_y(vis_y), .mode(mode), .arm(arm),
    .field_x0(field_x0), .field_x1(field_x1), .field_y(field_y),
    .text_x(text_x), .text_y(text_y), .h_shift(h_shift), .v_shift(v_shift),
    .row_len(row_len), .bitmap(bitmap), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .field_rgb(field_rgb), .starttrigger(trig0), .lit(lit0), .data(data0),
    .data_valid(dv0)
  );

  overlay_videogen #(
    .TEXT_ROWS(TR), .LINE_BITS(LB), .NUM_FIELDS(NF),
    .FRAME_PERIOD(4), .ON_FRAMES(2), .DITHER(1)
  ) u_dut1 (
    .clock(clock), .reset_n(reset_n), .frame_tick(frame_tick), .de(de),
    .vis_x(vis_x), .vis_y(vis_y), .mode(mode), .arm(arm),
    .field_x0(field_x0), .field_x1(field_x1), .field_y(field_y),
    .text_x(text_x), .text_y(text_y), .h_shift(h_shift), .v_shift(v_shift),
    .row_len(row_len), .bitmap(bitmap), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
    .field_rgb(field_rgb), .starttrigger(trig1), .lit(lit1), .data(data1),
    .data_valid(dv1)
  );

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;
  bit   exp_lit = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input int due, input int sel, input logic [31:0] exp, input string tag);
    exp_t e;
    e.due = due;
    e.sel = sel;
    e.exp = exp;
    e.tag = tag;
    sbq.push_back(e);
  endtask

  // Reference pixel: returns {data_valid, data}.
  function automatic logic [24:0] model_px(int x, int y, bit de_in, bit lit_in);
    int sx, base, off, len, top, h;
    bit in_band;
    if (!de_in) return 25'h0;
    in_band = 1'b0;
    for (int i = 0; i < int'(NF); i++) begin
      if (y >= int'(field_y[i*24+12 +: 12]) && y < int'(field_y[i*24 +: 12])) in_band = 1'b1;
    end
    if (lit_in && x >= int'(field_x0) && x < int'(field_x1) && in_band) return {1'b1, field_rgb};
    sx   = x >> h_shift;
    h    = 16 << v_shift;
    base = 0;
    for (int r = 0; r < int'(TR); r++) begin
      len = int'(row_len[r*12 +: 12]);
      top = int'(text_y) + r * h;
      if (y >= top && y < top + h && sx >= int'(text_x) && sx < int'(text_x) + len) begin
        off = base + sx - int'(text_x);
        if (off < int'(LB) && bitmap[int'(LB) - 1 - off]) return {1'b1, fg_rgb};
        return {1'b1, bg_rgb};
      end
      base += len;
    end
    return {1'b1, bg_rgb};
  endfunction

  always @(posedge clock) begin
    logic [31:0] obs;
    cyc = cyc + 1;
    #1;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].due <= cyc) begin
        case (sbq[i].sel)
          0:       obs = {7'b0, dv0, data0};
          1:       obs = {30'b0, trig0, lit0};
          2:       obs = {30'b0, trig1, lit1};
          default: obs = {7'b0, dv1, data1};
        endcase
        check_eq(sbq[i].tag, obs, sbq[i].exp);
        sbq.delete(i);
      end
    end
  end

  // One frame tick; e0/e1 are expected {starttrigger, lit} for each DUT after the tick.
  task automatic do_tick(input string tag, input logic [1:0] e0, input logic [1:0] e1);
    @(negedge clock);
    frame_tick = 1'b1;
    sb_push(cyc + 1, 1, {30'b0, e0}, {tag, "_d0"});
    sb_push(cyc + 1, 2, {30'b0, e1}, {tag, "_d1"});
    @(negedge clock);
    frame_tick = 1'b0;
    sb_push(cyc + 1, 1, {30'b0, 1'b0, e0[0]}, {tag, "_d0_end"});
    sb_push(cyc + 1, 2, {30'b0, 1'b0, e1[0]}, {tag, "_d1_end"});
    repeat (2) @(negedge clock);
  endtask

  task automatic drive_px(input int x, input int y, input bit d);
    logic [24:0] e;
    @(negedge clock);
    vis_x = 12'(x);
    vis_y = 12'(y);
    de    = d;
    e     = model_px(x, y, d, exp_lit);
    sb_push(cyc + 3, 0, {7'b0, e}, $sformatf("px0_%0d_%0d_%0d", x, y, d));
    sb_push(cyc + 3, 3, {7'b0, e}, $sformatf("px1_%0d_%0d_%0d", x, y, d));
  endtask

  task automatic pulse_arm();
    @(negedge clock);
    arm = 1'b1;
    @(negedge clock);
    arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int next1, k1, last1;
    logic [1:0] e0, e1;

    reset_n    = 1'b0;
    frame_tick = 1'b0;
    de         = 1'b0;
    arm        = 1'b0;
    vis_x      = '0;
    vis_y      = '0;
    mode       = 2'b00;
    field_x0   = 12'd30;
    field_x1   = 12'd50;
    field_y    = {12'd300, 12'd310, 12'd200, 12'd210, 12'd44, 12'd48};
    text_x     = 12'd20;
    text_y     = 12'd40;
    h_shift    = 2'd1;
    v_shift    = 2'd0;
    row_len    = {12'd0, 12'd600, 12'd16, 12'd8};
    bitmap     = {16{$urandom()}};
    bitmap[511] = 1'b1;
    bitmap[510] = 1'b0;
    bitmap[504] = 1'b0;
    bitmap[503] = 1'b1;
    bitmap[502] = 1'b0;
    bitmap[487] = 1'b1;
    bitmap[469] = 1'b1;
    bitmap[0]   = 1'b1;
    fg_rgb     = 24'h11AA33;
    bg_rgb     = 24'h203040;
    field_rgb  = 24'hF0F0F0;

    repeat (3) @(negedge clock);
    check_eq("rst_data0", {7'b0, dv0, data0}, 32'h0);
    check_eq("rst_seq0", {30'b0, trig0, lit0}, 32'h0);
    check_eq("rst_seq1", {30'b0, trig1, lit1}, 32'h0);
    reset_n = 1'b1;

    // Periodic: dut0 every 4 frames, dut1 with intervals growing 4, 5, 6, ...
    next1 = 0;
    k1    = 0;
    last1 = -100;
    for (int t = 0; t < 24; t++) begin
      e0 = {(t % 4) == 0, (t % 4) < 2};
      if (t == next1) begin
        last1 = t;
        next1 = t + 4 + k1;
        k1++;
      end
      e1 = {t == last1, (t - last1) < 2};
      do_tick($sformatf("per_t%0d", t), e0, e1);
    end

    // Continuous: fields lit, pixel checks including overlap and boundaries.
    mode = 2'b01;
    do_tick("cont0", 2'b11, 2'b11);
    do_tick("cont1", 2'b11, 2'b11);
    exp_lit = 1'b1;
    drive_px(40, 45, 1'b1);
    drive_px(35, 44, 1'b1);
    drive_px(35, 205, 1'b1);
    drive_px(50, 205, 1'b1);
    drive_px(35, 210, 1'b1);
    drive_px(40, 40, 1'b1);
    drive_px(41, 40, 1'b1);
    drive_px(42, 40, 1'b1);
    drive_px(40, 56, 1'b1);
    drive_px(56, 40, 1'b1);
    drive_px(70, 56, 1'b1);
    drive_px(72, 56, 1'b1);
    drive_px(40, 72, 1'b1);
    drive_px(1014, 72, 1'b1);
    drive_px(1016, 72, 1'b1);
    drive_px(1100, 72, 1'b1);
    drive_px(40, 88, 1'b1);
    drive_px(40, 40, 1'b0);
    for (int i = 0; i < 24; i++) begin
      drive_px(int'($urandom_range(0, 1200)), int'($urandom_range(30, 320)),
               $urandom_range(0, 3) != 0);
    end
    drive_px(0, 0, 1'b0);
    repeat (4) @(negedge clock);

    // Off: text shows through where the field would be.
    mode = 2'b10;
    do_tick("off0", 2'b00, 2'b00);
    exp_lit = 1'b0;
    drive_px(40, 45, 1'b1);
    drive_px(35, 205, 1'b1);
    drive_px(0, 0, 1'b0);
    repeat (4) @(negedge clock);
    do_tick("off1", 2'b00, 2'b00);

    // Single-shot: one burst per arm, arm during ON ignored.
    mode = 2'b11;
    do_tick("ss_enter", 2'b00, 2'b00);
    do_tick("ss_idle", 2'b00, 2'b00);
    pulse_arm();
    do_tick("ss_fire", 2'b11, 2'b11);
    pulse_arm();
    do_tick("ss_on2", 2'b01, 2'b01);
    do_tick("ss_done", 2'b00, 2'b00);
    do_tick("ss_quiet0", 2'b00, 2'b00);
    do_tick("ss_quiet1", 2'b00, 2'b00);
    pulse_arm();
    do_tick("ss_rearm", 2'b11, 2'b11);
    do_tick("ss_rearm_on", 2'b01, 2'b01);
    do_tick("ss_rearm_done", 2'b00, 2'b00);

    // Re-entering periodic restarts the frame counter.
    mode = 2'b00;
    do_tick("per_reenter", 2'b11, 2'b11);
    do_tick("per_reenter1", 2'b01, 2'b01);

    // Reset during a lit frame with live pixel data.
    mode = 2'b01;
    do_tick("pre_rst", 2'b11, 2'b11);
    exp_lit = 1'b1;
    drive_px(35, 205, 1'b1);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_eq("midrst_data0", {7'b0, dv0, data0}, 32'h0);
    check_eq("midrst_data1", {7'b0, dv1, data1}, 32'h0);
    check_eq("midrst_seq0", {30'b0, trig0, lit0}, 32'h0);
    check_eq("midrst_seq1", {30'b0, trig1, lit1}, 32'h0);
    de   = 1'b0;
    mode = 2'b00;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    do_tick("post_rst", 2'b11, 2'b11);
    do_tick("post_rst1", 2'b01, 2'b01);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clock);
    while (sbq.size() != 0) begin
      check_eq({"sb_timeout_", sbq[0].tag}, 32'h0, 32'h1);
      void'(sbq.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
